// File: rtl/mul_pipe_axis.sv
// Pipelined integer multiplier with valid/ready handshake, bubble collapsing and tag sideband.
// Define MUL_PIPE_SAT_EN to clamp narrowed products instead of wrapping (drives sat_flag).
module mul_pipe_axis #(
    parameter int DIN0_WIDTH  = 14,
    parameter int DIN1_WIDTH  = 12,
    parameter int DOUT_WIDTH  = 26,
    parameter int DIN0_SIGNED = 0,
    parameter int DIN1_SIGNED = 1,
    parameter int NUM_STAGE   = 2,
    parameter int TAG_WIDTH   = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  sat_flag
);

    localparam int FULL       = DIN0_WIDTH + DIN1_WIDTH;
    localparam int LAST       = NUM_STAGE - 1;
    localparam bit RES_SIGNED = (DIN0_SIGNED != 0) || (DIN1_SIGNED != 0);

    logic [FULL-1:0]       din0_ext;
    logic [FULL-1:0]       din1_ext;
    logic [FULL-1:0]       prod;
    logic [DOUT_WIDTH-1:0] res;
`ifdef MUL_PIPE_SAT_EN
    logic                  res_sat;
`endif

    generate
        if (DIN0_SIGNED != 0) begin : g_din0_sx
            assign din0_ext = {{DIN1_WIDTH{din0[DIN0_WIDTH-1]}}, din0};
        end else begin : g_din0_zx
            assign din0_ext = {{DIN1_WIDTH{1'b0}}, din0};
        end
        if (DIN1_SIGNED != 0) begin : g_din1_sx
            assign din1_ext = {{DIN0_WIDTH{din1[DIN1_WIDTH-1]}}, din1};
        end else begin : g_din1_zx
            assign din1_ext = {{DIN0_WIDTH{1'b0}}, din1};
        end
    endgenerate

    // Both operands extended to FULL bits, so the low FULL bits are the exact product.
    assign prod = din0_ext * din1_ext;

    generate
        if (DOUT_WIDTH < FULL) begin : g_narrow
`ifdef MUL_PIPE_SAT_EN
            logic                  ovf;
            logic [DOUT_WIDTH-1:0] clamp;
            if (RES_SIGNED) begin : g_sclamp
                assign ovf   = prod[FULL-1:DOUT_WIDTH-1] != {(FULL-DOUT_WIDTH+1){prod[FULL-1]}};
                assign clamp = prod[FULL-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                            : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
            end else begin : g_uclamp
                assign ovf   = |prod[FULL-1:DOUT_WIDTH];
                assign clamp = '1;
            end
            assign res     = ovf ? clamp : prod[DOUT_WIDTH-1:0];
            assign res_sat = ovf;
`else
            logic unused_prod_hi;
            assign unused_prod_hi = ^prod[FULL-1:DOUT_WIDTH];
            assign res            = prod[DOUT_WIDTH-1:0];
`endif
        end else if (DOUT_WIDTH == FULL) begin : g_exact
            assign res = prod;
`ifdef MUL_PIPE_SAT_EN
            assign res_sat = 1'b0;
`endif
        end else begin : g_wide
            assign res = {{(DOUT_WIDTH-FULL){RES_SIGNED ? prod[FULL-1] : 1'b0}}, prod};
`ifdef MUL_PIPE_SAT_EN
            assign res_sat = 1'b0;
`endif
        end
    endgenerate

    logic [NUM_STAGE-1:0]  v_q;
    logic [NUM_STAGE-1:0]  v_d;
    logic [NUM_STAGE-1:0]  en;
    logic [DOUT_WIDTH-1:0] data_q [NUM_STAGE];
    logic [DOUT_WIDTH-1:0] data_d [NUM_STAGE];
    logic [TAG_WIDTH-1:0]  tag_q  [NUM_STAGE];
    logic [TAG_WIDTH-1:0]  tag_d  [NUM_STAGE];
`ifdef MUL_PIPE_SAT_EN
    logic [NUM_STAGE-1:0]  sat_q;
    logic [NUM_STAGE-1:0]  sat_d;
`endif

    // A stage may load unless it and every stage downstream of it is full and stalled.
    always_comb begin : p_enable
        logic full_tail;
        full_tail = 1'b1;
        en        = '0;
        for (int k = LAST; k >= 0; k--) begin
            full_tail = full_tail & v_q[k];
            en[k]     = out_ready | ~full_tail;
        end
    end

    always_comb begin : p_next
        v_d    = v_q;
        data_d = data_q;
        tag_d  = tag_q;
`ifdef MUL_PIPE_SAT_EN
        sat_d  = sat_q;
`endif
        if (en[0]) begin
            v_d[0] = in_valid;
            if (in_valid) begin
                data_d[0] = res;
                tag_d[0]  = in_tag;
`ifdef MUL_PIPE_SAT_EN
                sat_d[0]  = res_sat;
`endif
            end
        end
        for (int k = 1; k < NUM_STAGE; k++) begin
            if (en[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                    tag_d[k]  = tag_q[k-1];
`ifdef MUL_PIPE_SAT_EN
                    sat_d[k]  = sat_q[k-1];
`endif
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            v_q <= '0;
            for (int k = 0; k < NUM_STAGE; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
`ifdef MUL_PIPE_SAT_EN
            sat_q <= '0;
`endif
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            tag_q  <= tag_d;
`ifdef MUL_PIPE_SAT_EN
            sat_q  <= sat_d;
`endif
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v_q[LAST];
    assign dout      = data_q[LAST];
    assign out_tag   = tag_q[LAST];
`ifdef MUL_PIPE_SAT_EN
    assign sat_flag  = sat_q[LAST];
`else
    assign sat_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_mul_pipe_axis.sv
// Directed bench for mul_pipe_axis: four instances cover default, 3-stage and 10x10->16 configurations.
module tb_mul_pipe_axis;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;
    logic aresetn;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: defaults (14u x 12s -> 26, 2 stages)
    logic        a_iv, a_ir, a_ov, a_or, a_sat;
    logic [13:0] a_d0;
    logic [11:0] a_d1;
    logic [7:0]  a_it, a_ot;
    logic [25:0] a_do;

    // Instance B: defaults but 3 stages
    logic        b_iv, b_ir, b_ov, b_or, b_sat;
    logic [13:0] b_d0;
    logic [11:0] b_d1;
    logic [7:0]  b_it, b_ot;
    logic [25:0] b_do;

    // Instances C (10u x 10u -> 16) and D (10u x 10s -> 16) share inputs
    logic        c_iv, c_or;
    logic [9:0]  c_d0, c_d1;
    logic [7:0]  c_it;
    logic        c_ir, c_ov, c_sat, d_ir, d_ov, d_sat;
    logic [7:0]  c_ot, d_ot;
    logic [15:0] c_do, d_do;

    mul_pipe_axis dut_a (
        .aclk(aclk), .aresetn(aresetn), .in_valid(a_iv), .in_ready(a_ir),
        .din0(a_d0), .din1(a_d1), .in_tag(a_it), .out_valid(a_ov), .out_ready(a_or),
        .dout(a_do), .out_tag(a_ot), .sat_flag(a_sat)
    );

    mul_pipe_axis #(.NUM_STAGE(3)) dut_b (
        .aclk(aclk), .aresetn(aresetn), .in_valid(b_iv), .in_ready(b_ir),
        .din0(b_d0), .din1(b_d1), .in_tag(b_it), .out_valid(b_ov), .out_ready(b_or),
        .dout(b_do), .out_tag(b_ot), .sat_flag(b_sat)
    );

    mul_pipe_axis #(.DIN0_WIDTH(10), .DIN1_WIDTH(10), .DOUT_WIDTH(16),
                    .DIN0_SIGNED(0), .DIN1_SIGNED(0)) dut_c (
        .aclk(aclk), .aresetn(aresetn), .in_valid(c_iv), .in_ready(c_ir),
        .din0(c_d0), .din1(c_d1), .in_tag(c_it), .out_valid(c_ov), .out_ready(c_or),
        .dout(c_do), .out_tag(c_ot), .sat_flag(c_sat)
    );

    mul_pipe_axis #(.DIN0_WIDTH(10), .DIN1_WIDTH(10), .DOUT_WIDTH(16),
                    .DIN0_SIGNED(0), .DIN1_SIGNED(1)) dut_d (
        .aclk(aclk), .aresetn(aresetn), .in_valid(c_iv), .in_ready(d_ir),
        .din0(c_d0), .din1(c_d1), .in_tag(c_it), .out_valid(d_ov), .out_ready(c_or),
        .dout(d_do), .out_tag(d_ot), .sat_flag(d_sat)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [25:0] exp26;
    logic [9:0]  c_tab_d0 [3];
    logic [9:0]  c_tab_d1 [3];
    logic [15:0] c_exp [3];
    logic [15:0] d_exp [3];
    logic        c_sexp [3];
    logic        d_sexp [3];
    int n_in, n_out;

    initial begin
        // 1000*1000, 1000*(1000 or -24), 3*5
        c_tab_d0[0] = 10'd1000; c_tab_d1[0] = 10'h3E8;
        c_tab_d0[1] = 10'd1000; c_tab_d1[1] = 10'h200;
        c_tab_d0[2] = 10'd3;    c_tab_d1[2] = 10'd5;
`ifdef MUL_PIPE_SAT_EN
        c_exp[0] = 16'hFFFF; c_sexp[0] = 1'b1;  d_exp[0] = 16'hA240; d_sexp[0] = 1'b0;
        c_exp[1] = 16'hFFFF; c_sexp[1] = 1'b1;  d_exp[1] = 16'h8000; d_sexp[1] = 1'b1;
`else
        c_exp[0] = 16'h4240; c_sexp[0] = 1'b0;  d_exp[0] = 16'hA240; d_sexp[0] = 1'b0;
        c_exp[1] = 16'hD000; c_sexp[1] = 1'b0;  d_exp[1] = 16'h3000; d_sexp[1] = 1'b0;
`endif
        c_exp[2] = 16'h000F; c_sexp[2] = 1'b0;  d_exp[2] = 16'h000F; d_sexp[2] = 1'b0;

        aresetn = 1'b0;
        a_iv = 0; a_or = 0; a_d0 = '0; a_d1 = '0; a_it = '0;
        b_iv = 0; b_or = 0; b_d0 = '0; b_d1 = '0; b_it = '0;
        c_iv = 0; c_or = 0; c_d0 = '0; c_d1 = '0; c_it = '0;
        #1;
        chk("rst_out_valid", a_ov, 1'b0);
        chk("rst_dout", a_do, 26'h0);
        chk("rst_out_tag", a_ot, 8'h0);
        chk("rst_sat_flag", a_sat, 1'b0);
        repeat (2) tick;
        aresetn = 1'b1;
        #1;
        chk("rst_in_ready_a", a_ir, 1'b1);
        chk("rst_in_ready_b", b_ir, 1'b1);

        // Single beat: 16383 * -2048
        a_or = 1; a_iv = 1; a_d0 = 14'h3FFF; a_d1 = 12'h800; a_it = 8'h5A;
        tick;
        a_iv = 0;
        chk("single_early_valid", a_ov, 1'b0);
        tick;
        chk("single_out_valid", a_ov, 1'b1);
        chk("single_dout", a_do, 26'h2000800);
        chk("single_tag", a_ot, 8'h5A);
        chk("single_sat", a_sat, 1'b0);
        tick;
        chk("single_valid_drop", a_ov, 1'b0);

        // Back-to-back stream i * -3
        for (int c = 0; c <= 21; c++) begin
            if (c < 20) begin
                a_iv = 1; a_d0 = 14'(c + 1); a_d1 = 12'hFFD; a_it = 8'(c + 1);
            end else begin
                a_iv = 0;
            end
            #1;
            if (c < 20) chk("stream_in_ready", a_ir, 1'b1);
            tick;
            if (c >= 1 && c <= 20) begin
                exp26 = 26'(-3 * c);
                chk("stream_valid", a_ov, 1'b1);
                chk("stream_dout", a_do, exp26);
                chk("stream_tag", a_ot, 8'(c));
            end else begin
                chk("stream_idle_valid", a_ov, 1'b0);
            end
        end

        // 3-stage backpressure fill then drain
        b_or = 0; n_in = 0; n_out = 0;
        for (int c = 0; c < 6; c++) begin
            b_iv = (n_in < 5); b_d0 = 14'(10 + n_in); b_d1 = 12'd2; b_it = 8'(n_in);
            #1;
            if (b_iv && b_ir) n_in++;
            tick;
        end
        chk("bp_accepted", n_in, 3);
        chk("bp_in_ready_low", b_ir, 1'b0);
        chk("bp_out_valid", b_ov, 1'b1);
        chk("bp_first_dout", b_do, 26'd20);
        chk("bp_first_tag", b_ot, 8'd0);
        repeat (3) begin
            tick;
            chk("bp_hold_dout", b_do, 26'd20);
        end
        b_or = 1;
        for (int c = 0; c < 30 && n_out < 5; c++) begin
            b_iv = (n_in < 5); b_d0 = 14'(10 + n_in); b_d1 = 12'd2; b_it = 8'(n_in);
            #1;
            if (b_ov && b_or) begin
                chk("drain_dout", b_do, 26'(20 + 2 * n_out));
                chk("drain_tag", b_ot, 8'(n_out));
                n_out++;
            end
            if (b_iv && b_ir) n_in++;
            tick;
        end
        b_iv = 0;
        chk("drain_count", n_out, 5);
        chk("drain_accepted", n_in, 5);
        chk("drain_no_dup", b_ov, 1'b0);

        // Narrow 16-bit result: wrap or clamp
        c_or = 1;
        for (int c = 0; c <= 3; c++) begin
            if (c < 3) begin
                c_iv = 1; c_d0 = c_tab_d0[c]; c_d1 = c_tab_d1[c]; c_it = 8'(8'h30 + c);
            end else begin
                c_iv = 0;
            end
            tick;
            if (c >= 1) begin
                chk("narrow_u_valid", c_ov, 1'b1);
                chk("narrow_u_dout", c_do, c_exp[c-1]);
                chk("narrow_u_sat", c_sat, c_sexp[c-1]);
                chk("narrow_s_dout", d_do, d_exp[c-1]);
                chk("narrow_s_sat", d_sat, d_sexp[c-1]);
                chk("narrow_s_tag", d_ot, 8'(8'h30 + c - 1));
            end
        end

        // Reset with two beats in flight
        a_or = 0; a_iv = 1; a_d0 = 14'd5; a_d1 = 12'd7; a_it = 8'd1;
        tick;
        a_d0 = 14'd6; a_it = 8'd2;
        tick;
        a_iv = 0;
        chk("pre_rst_valid", a_ov, 1'b1);
        chk("pre_rst_dout", a_do, 26'd35);
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_rst_valid", a_ov, 1'b0);
        chk("async_rst_dout", a_do, 26'h0);
        chk("async_rst_tag", a_ot, 8'h0);
        tick;
        tick;
        aresetn = 1'b1;
        #1;
        chk("post_rst_in_ready", a_ir, 1'b1);
        a_or = 1;
        repeat (4) begin
            tick;
            chk("post_rst_no_stale", a_ov, 1'b0);
        end

        // Gapped input with out_ready toggling out of phase
        n_in = 0; n_out = 0;
        for (int c = 0; c < 60 && n_out < 8; c++) begin
            a_iv = (c % 2 == 0) && (n_in < 8);
            a_d0 = 14'(100 + 37 * n_in);
            a_d1 = 12'(n_in - 4);
            a_it = 8'(8'hA0 + n_in);
            a_or = (c % 2 == 1);
            #1;
            if (a_ov && a_or) begin
                exp26 = 26'((100 + 37 * n_out) * (n_out - 4));
                chk("gap_dout", a_do, exp26);
                chk("gap_tag", a_ot, 8'(8'hA0 + n_out));
                n_out++;
            end
            if (a_iv && a_ir) n_in++;
            tick;
        end
        a_iv = 0;
        chk("gap_count", n_out, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
